uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmit byte port (write/writedata/wrfull of the UART controller) between
//  N_REQ independent byte-stream requesters. Arbitration is round-robin at packet granularity: a granted

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr_pick.sv | 40 ++++
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared constants for the UART transmit arbiter slice
//          (state encodings, byte width, grant index width).
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int BYTE_W  = 8;
    localparam int GRANT_W = 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin priority select. Returns the first
//          asserted request scanning i_rr_ptr, i_rr_ptr+1, ... mod N_REQ.
// Rev    : 1.0  initial release
// ============================================================================
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]   i_req,
    input  logic [GRANT_W-1:0] i_rr_ptr,
    output logic [GRANT_W-1:0] o_pick_id,
    output logic               o_any
);

    // Scan from the pointer, wrapping once; the first hit wins.
    always_comb begin : p_pick
        int idx;
        idx       = 0;
        o_pick_id = '0;
        o_any     = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = int'(i_rr_ptr) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            for (int j = 0; j < N_REQ; j++) begin
                if (!o_any && (j == idx) && i_req[j]) begin
                    o_any     = 1'b1;
                    o_pick_id = GRANT_W'(j);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_arbiter
// Brief  : Packet-granular round-robin arbiter sharing one UART TX byte port
//          between N_REQ requesters, with a stall watchdog that force-releases
//          an owner that stops sending mid-packet.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [BYTE_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      uart_write,
    output logic [BYTE_W-1:0]         uart_writedata,
    input  logic                      uart_wrfull,
    output logic                      busy,
    output logic [GRANT_W-1:0]        grant_id,
    output logic                      timeout_pulse
);

    localparam int               CNT_W      = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [GRANT_W-1:0] r_rr_ptr;
    logic [GRANT_W-1:0] r_grant_id;
    logic [CNT_W-1:0]   r_idle_cnt;

    logic [GRANT_W-1:0] w_pick_id;
    logic               w_any;
    logic               w_g_valid;
    logic               w_g_last;
    logic [BYTE_W-1:0]  w_g_data;
    logic [GRANT_W-1:0] w_next_ptr;
    logic               w_own;
    logic               w_accept;
    logic               w_stall;
    logic               w_expire;

    rr_pick #(
        .N_REQ     (N_REQ)
    ) u_rr_pick (
        .i_req     (req_valid),
        .i_rr_ptr  (r_rr_ptr),
        .o_pick_id (w_pick_id),
        .o_any     (w_any)
    );

    // Select the current owner's valid/last/data lanes.
    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant_id == GRANT_W'(i)) begin
                w_g_valid = req_valid[i];
                w_g_last  = req_last[i];
                w_g_data  = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign w_next_ptr = (r_grant_id == GRANT_W'(N_REQ - 1)) ? '0 : r_grant_id + 3'd1;
    assign w_own      = (r_state == ST_OWN);
    assign w_accept   = w_own & w_g_valid & ~uart_wrfull;
    // Backpressure is not a stall: the counter only advances when the port could take a byte.
    assign w_stall    = w_own & ~w_g_valid & ~uart_wrfull;
    assign w_expire   = w_stall & (r_idle_cnt == C_CNT_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: grant on any request, release on last-byte accept or watchdog expiry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_state_nxt = ST_OWN;
            ST_OWN:  if ((w_accept & w_g_last) | w_expire) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: route the owner's byte straight to the UART port, zero otherwise.
    always_comb begin
        req_ready      = '0;
        uart_write     = w_accept;
        uart_writedata = w_accept ? w_g_data : '0;
        busy           = w_own;
        timeout_pulse  = w_expire;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_own && (r_grant_id == GRANT_W'(i))) begin
                req_ready[i] = ~uart_wrfull;
            end
        end
    end

    // Grant index, round-robin pointer and watchdog counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_idle_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_any) begin
                r_grant_id <= w_pick_id;
                r_idle_cnt <= '0;
            end
        end else begin
            if (w_accept) begin
                r_idle_cnt <= '0;
                if (w_g_last) begin
                    r_rr_ptr <= w_next_ptr;
                end
            end else if (w_stall) begin
                if (w_expire) begin
                    r_rr_ptr   <= w_next_ptr;
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end
            end
        end
    end

    assign grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_arbiter
// Brief  : Self-checking bench for uart_tx_arbiter (N_REQ=4, TIMEOUT=8).
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        uart_write;
    logic [7:0]  uart_writedata;
    logic        uart_wrfull;
    logic        busy;
    logic [2:0]  grant_id;
    logic        timeout_pulse;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(
        .N_REQ          (4),
        .TIMEOUT        (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .uart_write     (uart_write),
        .uart_writedata (uart_writedata),
        .uart_wrfull    (uart_wrfull),
        .busy           (busy),
        .grant_id       (grant_id),
        .timeout_pulse  (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        full;
        logic [3:0]  e_ready;
        logic        e_write;
        logic [7:0]  e_wdata;
        logic        e_busy;
        logic [2:0]  e_gid;
        logic        e_tp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                                input logic f, input logic [3:0] er, input logic ew,
                                input logic [7:0] ed, input logic eb, input logic [2:0] eg,
                                input logic et);
        vec_t r;
        r = '{valid:v, data:d, last:l, full:f, e_ready:er, e_write:ew,
              e_wdata:ed, e_busy:eb, e_gid:eg, e_tp:et};
        return r;
    endfunction

    task automatic idle_inputs();
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        uart_wrfull = 1'b0;
    endtask

    // Reset for two cycles; leaves us at a negedge with reset low.
    task automatic do_reset(input bit check_state);
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        #1;
        if (check_state) begin
            chk("reset_outputs",
                32'({req_ready, uart_write, uart_writedata, busy, grant_id, timeout_pulse}), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : main
        int n_wr;
        int sent;
        logic [31:0] act;
        logic [31:0] exp;
        reset = 1'b1;
        idle_inputs();

        // ---------------- table-driven: two 3-byte packets, then rr_ptr check
        vecs.push_back(mk(4'b0011, 32'h0000B0A0, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 3'd0, 0));
        vecs.push_back(mk(4'b0011, 32'h0000B0A0, 4'b0000, 0, 4'b0001, 1, 8'hA0, 1, 3'd0, 0));
        vecs.push_back(mk(4'b0011, 32'h0000B0A1, 4'b0000, 0, 4'b0001, 1, 8'hA1, 1, 3'd0, 0));
        vecs.push_back(mk(4'b0011, 32'h0000B0A2, 4'b0001, 0, 4'b0001, 1, 8'hA2, 1, 3'd0, 0));
        vecs.push_back(mk(4'b0010, 32'h0000B000, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 3'd0, 0));
        vecs.push_back(mk(4'b0010, 32'h0000B000, 4'b0000, 0, 4'b0010, 1, 8'hB0, 1, 3'd1, 0));
        vecs.push_back(mk(4'b0010, 32'h0000B100, 4'b0000, 0, 4'b0010, 1, 8'hB1, 1, 3'd1, 0));
        vecs.push_back(mk(4'b0010, 32'h0000B200, 4'b0010, 0, 4'b0010, 1, 8'hB2, 1, 3'd1, 0));
        vecs.push_back(mk(4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 3'd1, 0));
        vecs.push_back(mk(4'b1111, 32'h33221100, 4'b1111, 0, 4'b0000, 0, 8'h00, 0, 3'd1, 0));
        vecs.push_back(mk(4'b1111, 32'h33221100, 4'b1111, 1, 4'b0000, 0, 8'h00, 1, 3'd2, 0));
        vecs.push_back(mk(4'b1111, 32'h33221100, 4'b1111, 0, 4'b0100, 1, 8'h22, 1, 3'd2, 0));
        vecs.push_back(mk(4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 3'd2, 0));

        do_reset(1'b1);
        for (int i = 0; i < vecs.size(); i++) begin
            req_valid   = vecs[i].valid;
            req_data    = vecs[i].data;
            req_last    = vecs[i].last;
            uart_wrfull = vecs[i].full;
            #1;
            act = 32'({req_ready, uart_write, uart_writedata, busy, grant_id, timeout_pulse});
            exp = 32'({vecs[i].e_ready, vecs[i].e_write, vecs[i].e_wdata,
                       vecs[i].e_busy, vecs[i].e_gid, vecs[i].e_tp});
            chk($sformatf("vec%0d", i), act, exp);
            @(negedge clk);
        end

        // ---------------- reset mid-packet from requester 2
        do_reset(1'b0);
        req_valid = 4'b0100;
        req_data  = 32'h005A0000;
        #1;
        @(negedge clk);
        #1;
        chk("rst_pre_write", 32'({uart_write, grant_id}), 32'({1'b1, 3'd2}));
        #1;
        reset = 1'b1;
        #1;
        chk("rst_async_busy",  32'(busy), 32'd0);
        chk("rst_async_write", 32'({uart_write, req_ready}), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 4'b0001;
        req_data  = 32'h00000011;
        #1;
        chk("rst_after_idle", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        chk("rst_after_grant", 32'({busy, grant_id}), 32'({1'b1, 3'd0}));

        // ---------------- backpressure for 5 cycles during requester 3 packet
        do_reset(1'b0);
        sent = 0;
        n_wr = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            uart_wrfull = (cyc >= 3 && cyc < 8);
            req_valid   = (sent < 4) ? 4'b1000 : 4'b0000;
            req_last    = (sent == 3) ? 4'b1000 : 4'b0000;
            req_data    = {8'(8'hC0 + sent), 24'h0};
            #1;
            if (uart_wrfull) begin
                chk("bp_no_write", 32'({uart_write, req_ready}), 32'd0);
            end
            if (timeout_pulse) begin
                chk("bp_no_timeout", 32'(timeout_pulse), 32'd0);
            end
            if (uart_write) begin
                chk("bp_byte_order", 32'(uart_writedata), 32'(8'hC0 + n_wr));
                n_wr++;
            end
            if (req_valid[3] && req_ready[3]) sent++;
            @(negedge clk);
        end
        chk("bp_bytes_written", 32'(n_wr), 32'd4);

        // ---------------- watchdog: requester 1 stalls, requester 2 waiting
        do_reset(1'b0);
        req_valid = 4'b0110;
        req_data  = 32'h00222100;
        #1;
        @(negedge clk);
        #1;
        chk("wd_first_byte", 32'({uart_write, uart_writedata, grant_id}), 32'({1'b1, 8'h21, 3'd1}));
        @(negedge clk);
        req_valid = 4'b0100;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk($sformatf("wd_pulse_c%0d", k), 32'({timeout_pulse, busy}), 32'({k == 8, 1'b1}));
            @(negedge clk);
        end
        #1;
        chk("wd_released", 32'({busy, timeout_pulse, req_ready}), 32'd0);
        @(negedge clk);
        #1;
        chk("wd_next_grant", 32'({busy, grant_id}), 32'({1'b1, 3'd2}));

        // ---------------- all requesters continuously valid, 1-byte packets
        do_reset(1'b0);
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_data  = 32'h33221100;
        n_wr = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            #1;
            if ((cyc % 2) == 1) begin
                chk($sformatf("fair_c%0d", cyc), 32'({uart_write, grant_id, uart_writedata}),
                    32'({1'b1, 3'((cyc / 2) % 4), 8'(8'h11 * ((cyc / 2) % 4))}));
            end else begin
                chk($sformatf("fair_gap_c%0d", cyc), 32'(uart_write), 32'd0);
            end
            if (uart_write) n_wr++;
            @(negedge clk);
        end
        chk("fair_duty", 32'(n_wr), 32'd8);

        // ---------------- random traffic with per-requester scoreboard
        do_reset(1'b0);
        begin : rnd
            logic [5:0] seq[4];
            int plen[4];
            int pos[4];
            int owner;
            bit in_pkt;
            int a;
            int nacc;
            logic [3:0] acc;
            owner  = 0;
            in_pkt = 0;
            n_wr   = 0;
            for (int i = 0; i < 4; i++) begin
                seq[i]  = '0;
                pos[i]  = 0;
                plen[i] = int'($urandom_range(1, 4));
            end
            for (int cyc = 0; cyc < 10000; cyc++) begin
                uart_wrfull = ($urandom_range(0, 3) == 0);
                for (int i = 0; i < 4; i++) begin
                    req_valid[i]         = ($urandom_range(0, 9) < 7);
                    req_last[i]          = (pos[i] == plen[i] - 1);
                    req_data[i*8 +: 8]   = {2'(i), seq[i]};
                end
                #1;
                acc  = req_valid & req_ready;
                nacc = $countones(acc);
                if (uart_wrfull) chk("rnd_full_no_write", 32'({uart_write, req_ready}), 32'd0);
                chk("rnd_accept_is_write", 32'(nacc), 32'(uart_write));
                if (!uart_write) chk("rnd_wdata_zero", 32'(uart_writedata), 32'd0);
                if (nacc == 1) begin
                    a = 0;
                    for (int j = 0; j < 4; j++) if (acc[j]) a = j;
                    chk("rnd_byte", 32'(uart_writedata), 32'({2'(a), seq[a]}));
                    if (in_pkt) chk("rnd_contiguous", 32'(a), 32'(owner));
                    n_wr++;
                    seq[a] = seq[a] + 6'd1;
                    if (req_last[a]) begin
                        pos[a]  = 0;
                        plen[a] = int'($urandom_range(1, 4));
                        in_pkt  = 0;
                    end else begin
                        pos[a]++;
                        in_pkt = 1;
                        owner  = a;
                    end
                end
                if (timeout_pulse) in_pkt = 0;
                @(negedge clk);
            end
            chk("rnd_progress", 32'(n_wr > 2000), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
